// File: rtl/fetch_pkg.sv
// Shared state encoding and default widths for the fetch stage.
// Imported by fetch_unit; no logic of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } fetch_state_t;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;

endpackage

// File: rtl/vDFFR.sv
// Enabled register with asynchronous active-low reset to a parameter value.
// One-cycle latency from d to q; holds when en is low.
module vDFFR #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage sharing one req/ack memory port with a prioritised data-access port.
// Fetch latency 2 cycles at zero-wait memory; IR is held until decode raises ir_ready or a branch squashes it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  ir_ready,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  dacc_req,
  input  logic                  dacc_we,
  input  logic [ADDR_WIDTH-1:0] dacc_addr,
  input  logic [DATA_WIDTH-1:0] dacc_wdata,
  output logic                  dacc_done,
  output logic [DATA_WIDTH-1:0] dacc_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  output logic [ADDR_WIDTH-1:0] ir_pc
);

  fetch_state_t state, state_nxt;
  logic squash;
  logic start_dacc, start_fetch, lat_en;
  logic fetch_done, fetch_keep, pc_en, rdata_en;
  logic lat_we;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_d, lat_addr, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_dacc  = 1'b0;
    start_fetch = 1'b0;
    case (state)
      IDLE: begin
        if (dacc_req) begin
          state_nxt  = DACC;
          start_dacc = 1'b1;
        end else if (fetch_en && (!ir_valid || ir_ready)) begin
          state_nxt   = IFETCH;
          start_fetch = 1'b1;
        end
      end
      IFETCH, DACC: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_done = (state == IFETCH) && mem_ack;
  assign fetch_keep = fetch_done && !squash && !branch_valid;
  assign dacc_done  = (state == DACC) && mem_ack;
  assign rdata_en   = dacc_done && !lat_we;

  assign pc_en      = branch_valid || fetch_keep;
  assign fetch_pc_d = branch_valid ? branch_target : fetch_pc + ADDR_WIDTH'(1);

  // Fetch address is latched too, so a branch mid-fetch cannot move mem_addr;
  // a branch at the launch edge fetches the target directly.
  assign lat_en     = start_dacc || start_fetch;
  assign lat_addr_d = start_dacc   ? dacc_addr :
                      branch_valid ? branch_target : fetch_pc;

  assign mem_req   = (state != IDLE);
  assign mem_addr  = lat_addr;
  assign mem_we    = lat_we;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash   <= 1'b0;
      ir_valid <= 1'b0;
    end else begin
      if (branch_valid && (state == IFETCH) && !mem_ack) squash <= 1'b1;
      else if (fetch_done)                                squash <= 1'b0;

      if (branch_valid)    ir_valid <= 1'b0;
      else if (fetch_keep) ir_valid <= 1'b1;
      else if (ir_ready)   ir_valid <= 1'b0;
    end
  end

  vDFFR #(.W(ADDR_WIDTH), .RST_VAL(RESET_PC)) u_fetch_pc (
    .clk(clk), .reset(reset), .en(pc_en), .d(fetch_pc_d), .q(fetch_pc)
  );

  vDFFR #(.W(DATA_WIDTH)) u_ir (
    .clk(clk), .reset(reset), .en(fetch_keep), .d(mem_rdata), .q(ir)
  );

  vDFFR #(.W(ADDR_WIDTH)) u_ir_pc (
    .clk(clk), .reset(reset), .en(fetch_keep), .d(fetch_pc), .q(ir_pc)
  );

  vDFFR #(.W(ADDR_WIDTH)) u_lat_addr (
    .clk(clk), .reset(reset), .en(lat_en), .d(lat_addr_d), .q(lat_addr)
  );

  vDFFR #(.W(1)) u_lat_we (
    .clk(clk), .reset(reset), .en(lat_en), .d(start_dacc && dacc_we), .q(lat_we)
  );

  vDFFR #(.W(DATA_WIDTH)) u_lat_wdata (
    .clk(clk), .reset(reset), .en(start_dacc), .d(dacc_wdata), .q(lat_wdata)
  );

  vDFFR #(.W(DATA_WIDTH)) u_dacc_rdata (
    .clk(clk), .reset(reset), .en(rdata_en), .d(mem_rdata), .q(dacc_rdata)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored against
// an instruction-stream / data-memory reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0, ir_ready = 1'b0, branch_valid = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        dacc_req = 1'b0, dacc_we = 1'b0;
  logic [7:0]  dacc_addr = '0;
  logic [15:0] dacc_wdata = '0;
  logic        dacc_done;
  logic [15:0] dacc_rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  ir_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RESET_PC(8'h10)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .ir_ready(ir_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .dacc_req(dacc_req), .dacc_we(dacc_we), .dacc_addr(dacc_addr),
    .dacc_wdata(dacc_wdata), .dacc_done(dacc_done), .dacc_rdata(dacc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc)
  );

  // Memory device: wait_max wait cycles per transaction (or random 0..wait_max).
  logic [15:0] mem [256];
  int wait_max  = 0;
  bit rand_wait = 1'b0;
  int cnt = 0, cur_wait = 0;
  bit busy = 1'b0;

  always @(negedge clk) begin
    if (!mem_req) begin
      busy = 1'b0; cnt = 0; mem_ack = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1'b1; cnt = 0;
        cur_wait = rand_wait ? int'($urandom_range(0, wait_max)) : wait_max;
      end
      if (cnt >= cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit fe, input bit rdy, input int w);
    reset = 1'b0; fetch_en = fe; ir_ready = rdy; branch_valid = 1'b0;
    dacc_req = 1'b0; wait_max = w; rand_wait = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  task automatic wait_vld(input string tag);
    int k = 0;
    while (!ir_valid && k < 20) begin
      cyc();
      k++;
    end
    chk({tag, "_vld_timeout"}, ir_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model state for the randomized run.
  logic [15:0] dref [8];
  logic [7:0]  exp_pc;
  int          consumed, dwait;
  logic        p_vld, p_done, p_req, p_ack, p_we, hold_req, h_we;
  logic [15:0] p_ir, p_wd, h_wd;
  logic [7:0]  p_pc, p_addr, h_addr;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'(a) + 16'h0100;
    for (int i = 0; i < 8; i++) dref[i] = 16'h01E0 + 16'(i);

    // Reset values, then zero-wait sequential fetch from RESET_PC.
    reset = 1'b0; fetch_en = 1'b1; ir_ready = 1'b1; wait_max = 0;
    cyc(2);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_ir_pc", ir_pc, 8'h0);
    chk("rst_dacc_done", dacc_done, 1'b0);
    chk("rst_dacc_rdata", dacc_rdata, 16'h0);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("seq_mem_req", mem_req, (k % 2 == 0));
      chk("seq_ir_valid", ir_valid, (k % 2 == 1));
      if (k == 0) chk("seq_first_addr", mem_addr, 8'h10);
      if (k % 2 == 1) begin
        chk("seq_ir", ir, 16'h0110 + 16'(k / 2));
        chk("seq_ir_pc", ir_pc, 8'h10 + 8'(k / 2));
      end
    end

    // Three wait cycles, fetch from 0xFF then wrap to 0x00.
    do_reset(1'b0, 1'b1, 3);
    branch_valid = 1'b1; branch_target = 8'hFF;
    cyc();
    branch_valid = 1'b0; fetch_en = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("wait_mem_req", mem_req, 1'b1);
      chk("wait_mem_addr", mem_addr, 8'hFF);
      chk("wait_ir_valid", ir_valid, 1'b0);
      cyc();
    end
    chk("wait_ack_vld", ir_valid, 1'b1);
    chk("wait_ack_ir", ir, 16'h01FF);
    chk("wait_ack_pc", ir_pc, 8'hFF);
    cyc();
    chk("wrap_mem_req", mem_req, 1'b1);
    chk("wrap_mem_addr", mem_addr, 8'h00);

    // Decode stall: IR held, no new fetch until ir_ready rises.
    do_reset(1'b1, 1'b0, 0);
    cyc(2);
    chk("stall_vld", ir_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stall_mem_req", mem_req, 1'b0);
      chk("stall_ir", ir, 16'h0110);
    end
    ir_ready = 1'b1;
    cyc();
    chk("unstall_mem_req", mem_req, 1'b1);
    chk("unstall_mem_addr", mem_addr, 8'h11);
    chk("unstall_vld", ir_valid, 1'b0);

    // Branch during a waiting fetch.
    do_reset(1'b1, 1'b1, 3);
    cyc();
    branch_valid = 1'b1; branch_target = 8'h40;
    cyc();
    branch_valid = 1'b0;
    chk("brw_vld", ir_valid, 1'b0);
    chk("brw_addr_stable", mem_addr, 8'h10);
    cyc(3);
    chk("brw_drop_req", mem_req, 1'b0);
    chk("brw_drop_vld", ir_valid, 1'b0);
    cyc();
    chk("brw_next_addr", mem_addr, 8'h40);
    wait_vld("brw");
    chk("brw_ir", ir, 16'h0140);
    chk("brw_ir_pc", ir_pc, 8'h40);

    // Branch coincident with mem_ack.
    do_reset(1'b1, 1'b1, 0);
    cyc();
    branch_valid = 1'b1; branch_target = 8'h40;
    cyc();
    branch_valid = 1'b0;
    chk("brc_vld", ir_valid, 1'b0);
    cyc();
    chk("brc_mem_req", mem_req, 1'b1);
    chk("brc_next_addr", mem_addr, 8'h40);
    wait_vld("brc");
    chk("brc_ir", ir, 16'h0140);

    // Data access beats fetch; write then read back.
    do_reset(1'b1, 1'b1, 0);
    dacc_req = 1'b1; dacc_we = 1'b1; dacc_addr = 8'h05; dacc_wdata = 16'hBEEF;
    cyc();
    chk("dw_mem_we", mem_we, 1'b1);
    chk("dw_mem_addr", mem_addr, 8'h05);
    chk("dw_mem_wdata", mem_wdata, 16'hBEEF);
    @(negedge clk); #2;
    chk("dw_done", dacc_done, 1'b1);
    @(posedge clk); #1;
    dacc_req = 1'b0;
    chk("dw_mem_written", mem[5], 16'hBEEF);
    dacc_req = 1'b1; dacc_we = 1'b0;
    cyc();
    chk("dr_mem_req", mem_req, 1'b1);
    chk("dr_mem_we", mem_we, 1'b0);
    chk("dr_mem_addr", mem_addr, 8'h05);
    cyc();
    dacc_req = 1'b0;
    chk("dr_rdata", dacc_rdata, 16'hBEEF);
    cyc();
    chk("resume_mem_addr", mem_addr, 8'h10);
    chk("resume_mem_we", mem_we, 1'b0);
    mem[5] = 16'h0105;

    // Reset asserted in the middle of a waiting data access.
    fetch_en = 1'b0;
    wait_vld("pre_rst");
    ir_ready = 1'b0; wait_max = 3;
    dacc_req = 1'b1; dacc_we = 1'b0; dacc_addr = 8'h07;
    cyc();
    chk("mid_mem_req", mem_req, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_dacc_done", dacc_done, 1'b0);
    chk("arst_ir_valid", ir_valid, 1'b0);
    chk("arst_ir", ir, 16'h0);
    chk("arst_ir_pc", ir_pc, 8'h0);
    chk("arst_dacc_rdata", dacc_rdata, 16'h0);
    chk("arst_mem_addr", mem_addr, 8'h0);
    dacc_req = 1'b0;

    // Randomized run against the instruction-stream and data-memory model.
    do_reset(1'b1, 1'b1, 2);
    rand_wait = 1'b1;
    exp_pc = 8'h10; consumed = 0; dwait = 0; hold_req = 1'b0;
    h_addr = '0; h_we = 1'b0; h_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      fetch_en      = ($urandom_range(0, 7) != 0);
      ir_ready      = ($urandom_range(0, 2) != 0);
      branch_valid  = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom_range(0, 63));
      if (!dacc_req && $urandom_range(0, 9) == 0) begin
        dacc_req   = 1'b1;
        dacc_we    = 1'($urandom_range(0, 1));
        dacc_addr  = 8'hE0 + 8'($urandom_range(0, 7));
        dacc_wdata = 16'($urandom);
        dwait      = 0;
      end
      @(negedge clk); #2;
      p_vld = ir_valid; p_ir = ir; p_pc = ir_pc; p_done = dacc_done;
      p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
      if (p_req && hold_req) begin
        chk("rnd_addr_stable", p_addr, h_addr);
        chk("rnd_we_stable", p_we, h_we);
        chk("rnd_wdata_stable", p_wd, h_wd);
      end
      hold_req = p_req && !p_ack; h_addr = p_addr; h_we = p_we; h_wd = p_wd;
      @(posedge clk); #1;
      if (branch_valid) begin
        exp_pc = branch_target;
      end else if (p_vld && ir_ready) begin
        chk("rnd_ir_pc", p_pc, exp_pc);
        if (p_pc < 8'hE0) chk("rnd_ir", p_ir, 16'(p_pc) + 16'h0100);
        exp_pc = exp_pc + 8'd1;
        consumed++;
      end
      if (dacc_req) begin
        if (p_done) begin
          if (dacc_we) dref[dacc_addr[2:0]] = dacc_wdata;
          else         chk("rnd_dacc_rdata", dacc_rdata, dref[dacc_addr[2:0]]);
          dacc_req = 1'b0;
        end else begin
          dwait++;
          if (dwait > 40) begin
            chk("rnd_dacc_timeout", p_done, 1'b1);
            dacc_req = 1'b0;
          end
        end
      end
    end
    chk("rnd_progress", (consumed > 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage. It holds the program counter and owns the single memory port through a req/ack handshake, so memory may have any latency. It loads fetched words into an instruction register handed to decode over a valid/ready handshake, and supports branch redirection with squash. It also arbitrates a data-access port (load/store) onto the same memory port, with priority over instruction fetch.

## Interface
- ADDR_WIDTH, 8, width of PC and memory address
- DATA_WIDTH, 16, width of instruction/data word
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new instruction fetches
- ir_ready  in  1  decode accepts IR this cycle
- branch_valid  in  1  redirect PC this cycle
- branch_target  in  ADDR_WIDTH  new PC when branch_valid
- dacc_req  in  1  data access request, held until dacc_done
- dacc_we  in  1  1 = write, 0 = read
- dacc_addr  in  ADDR_WIDTH  data address
- dacc_wdata  in  DATA_WIDTH  write data
- dacc_done  out  1  data access completes this cycle
- dacc_rdata  out  DATA_WIDTH  last read data
- mem_req  out  1  memory transaction pending
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completes transaction at this edge
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack
- ir  out  DATA_WIDTH  instruction register
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_pc  out  ADDR_WIDTH  address ir was fetched from

## Operation
- State machine states:
  - IDLE: no memory transaction.
  - IFETCH: instruction fetch in flight.
  - DACC: data access in flight.
- IDLE transitions:
  - IDLE→DACC if dacc_req. Latch dacc_addr, dacc_we and dacc_wdata into the memory-side registers. Data access has priority.
  - Else IDLE→IFETCH if fetch_en && (!ir_valid || ir_ready).
- Memory-port outputs:
  - mem_req = 1 in IFETCH and DACC, 0 in IDLE. It has no combinational path from inputs.
  - IFETCH: mem_addr = fetch_pc, mem_we = 0.
  - DACC: mem_addr, mem_we and mem_wdata come from the latched values.
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high.
- Transaction completion: completes at the edge where mem_req && mem_ack, then returns to IDLE. A transaction is never aborted.
- IFETCH completion, not squashed: ir←mem_rdata, ir_pc←fetch_pc, ir_valid←1, fetch_pc←fetch_pc+1 modulo 2^ADDR_WIDTH (2^ADDR_WIDTH−1 wraps to 0).
- IFETCH completion, squashed: data discarded, ir/ir_valid untouched, squash cleared.
- DACC completion:
  - dacc_done = (state==DACC) && mem_ack, combinational.
  - Reads only: dacc_rdata←mem_rdata; it holds until the next DACC read.
  - The requester deasserts dacc_req at the edge where dacc_done is high.
- IR consumption: ir_valid && ir_ready at an edge clears ir_valid, unless a fetch completes at the same edge, in which case ir_valid stays 1 with new contents.
- Branch: branch_valid at an edge does all of the following:
  - fetch_pc←branch_target.
  - ir_valid←0.
  - If state is IFETCH and mem_ack is 0, squash←1.
  - If mem_ack is 1 in IFETCH, the arriving word is discarded.
  - Branch has priority over fetch completion and consumption.
  - Branch during DACC updates only fetch_pc; the DACC proceeds.
- Reset values (asynchronous): state IDLE, fetch_pc RESET_PC, ir 0, ir_pc 0, ir_valid 0, squash 0, dacc_rdata 0, latched data regs 0, mem_req 0, dacc_done 0.
- Reset asserted mid-transaction drops mem_req immediately. Memory must tolerate a req withdrawn without ack.

## Timing
- Zero-wait memory (mem_ack high in the first cycle of mem_req): fetch latency is 2 cycles from IDLE-with-conditions to ir_valid. Sustained throughput is 1 instruction per 2 cycles.
- N wait cycles add N cycles per transaction.
- First mem_req after reset deassertion: cycle 1, provided fetch_en is high in cycle 0.
- fetch_en low only blocks new fetches; an in-flight IFETCH still completes.

## Structure
- Shared package fetch_pkg holds the state encoding (IDLE=2'd0, IFETCH=2'd1, DACC=2'd2) and default width constants.
- One sub-module, vDFFR: a parametrised register with asynchronous active-low reset and reset-value parameter. It is used for fetch_pc, ir, ir_pc and the latched data registers.

## Test plan
- Reset with RESET_PC=8'h10, fetch_en=1, ir_ready=1, zero-wait memory where rdata = addr+16'h100 → ir sequence 16'h0110, 0111, 0112; ir_pc 10, 11, 12; ir_valid one cycle every 2.
- 3-cycle ack delay: mem_addr and mem_req stable throughout; ir updates only at the ack edge; fetch_pc at 8'hFF wraps to 8'h00.
- ir_ready=0 with ir_valid=1 → no new mem_req; ir held. Raise ir_ready → IFETCH next cycle.
- branch_valid with target 8'h40 during IFETCH wait → returned word dropped, ir_valid=0, next mem_addr=8'h40. Repeat with branch coincident with mem_ack → same result.
- dacc_req and fetch conditions both present in IDLE → DACC wins. Write 16'hBEEF to 8'h05, then read 8'h05 → dacc_rdata=16'hBEEF the cycle after dacc_done; fetch then resumes.
- Reset asserted during DACC wait → mem_req drops asynchronously; all outputs at reset values.
